// File: rtl/pc_redirect.sv
// pc_redirect -- fetch program counter with a deferred-redirect holding register.
//
// F_PC advances by 4 whenever fetch can move (no stall, memory accepted the
// address). Control transfers resolved in D (taken branch, j/jal, jr) become
// the next F_PC. If fetch cannot move in the cycle the transfer resolves, the
// target is parked in a holding register and replayed on the next advance.
// The instruction already in F when the transfer resolves is kept, which
// gives the delay slot without any extra logic.
//
// Ports:
//   clk              single clock, rising edge
//   reset            synchronous, active-high
//   stall            hazard stall; F and D frozen, D control ignored
//   imem_ready       instruction memory accepted F_PC this cycle
//   NPCOp            D control: 001 branch, 010 j/jal, 011 jr, else sequential
//   b_result         branch comparator decision for the D instruction
//   D_PC             PC of the D-stage instruction
//   D_imm16          branch offset field
//   D_imm26          jump index field
//   D_rs_val         forwarded rs, used unmodified as the jr target
//   F_PC             current fetch address (registered)
//   redirect_pending a resolved target is held, waiting for fetch to advance
//   F_adel           F_PC misaligned or outside [IM_LO, IM_HI]
module pc_redirect #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_LO    = 32'h0000_3000,
  parameter logic [31:0] IM_HI    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic [2:0]  NPCOp,
  input  logic        b_result,
  input  logic [31:0] D_PC,
  input  logic [15:0] D_imm16,
  input  logic [25:0] D_imm26,
  input  logic [31:0] D_rs_val,
  output logic [31:0] F_PC,
  output logic        redirect_pending,
  output logic        F_adel
);

  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JR     = 3'b011;

  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] redirect_target;
  logic        redirect_now;
  logic        advance;
  logic [31:0] held_target;

  // Offset is a word count: sign-extend then scale by 4; wraps modulo 2^32.
  assign branch_target = D_PC + 32'd4 + {{14{D_imm16[15]}}, D_imm16, 2'b00};
  assign jump_target   = {D_PC[31:28], D_imm26, 2'b00};

  // While stalled the D instruction is frozen and re-resolves once released,
  // so its control must not be acted on here.
  assign redirect_now = !stall &&
                        ((NPCOp == NPC_BRANCH && b_result) ||
                         NPCOp == NPC_JUMP || NPCOp == NPC_JR);

  assign advance = !stall && imem_ready;

  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    redirect_target = branch_target;
    case (NPCOp)
      NPC_JUMP: redirect_target = jump_target;
      NPC_JR:   redirect_target = D_rs_val;
      default:  redirect_target = branch_target;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      F_PC             <= PC_RESET;
      redirect_pending <= 1'b0;
      // NOTE: the holding register is only read when redirect_pending is set, but it is cleared anyway so post-reset state is fully defined.
      held_target      <= 32'h0;
    end else if (advance) begin
      if (redirect_now)          F_PC <= redirect_target;
      else if (redirect_pending) F_PC <= held_target;
      else                       F_PC <= F_PC + 32'd4;
      redirect_pending <= 1'b0;
    end else if (redirect_now) begin
      // Fetch cannot move: park the target; a newer resolution overwrites an older one.
      held_target      <= redirect_target;
      redirect_pending <= 1'b1;
    end
  end

  // Diagnostic only; sequencing is unaffected by an illegal fetch address.
  assign F_adel = (F_PC[1:0] != 2'b00) || (F_PC < IM_LO) || (F_PC > IM_HI);

endmodule

// File: doc/pc_redirect.md
PC_REDIRECT -- requirements
Module: pc_redirect

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_3000, the fetch address loaded on reset.
REQ-002 SHALL have parameter IM_LO, default 32'h0000_3000, the lowest legal fetch address.
REQ-003 SHALL have parameter IM_HI, default 32'h0000_6FFC, the highest legal fetch address.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port stall  input  1  hazard stall; freezes F and D, so the D instruction is not consumed.
REQ-007 SHALL have port imem_ready  input  1  instruction memory accepted F_PC this cycle.
REQ-008 SHALL have port NPCOp  input  3  D-stage control: 000 sequential, 001 branch, 010 j/jal, 011 jr, others sequential.
REQ-009 SHALL have port b_result  input  1  branch-comparator decision for the D instruction.
REQ-010 SHALL have port D_PC  input  32  PC of the D-stage instruction.
REQ-011 SHALL have port D_imm16  input  16  branch offset field.
REQ-012 SHALL have port D_imm26  input  26  jump index field.
REQ-013 SHALL have port D_rs_val  input  32  forwarded rs value, used as the jr target.
REQ-014 SHALL have port F_PC  output  32  current fetch address, registered.
REQ-015 SHALL have port redirect_pending  output  1  a resolved redirect is held, waiting for fetch to advance.
REQ-016 SHALL have port F_adel  output  1  F_PC is misaligned or outside [IM_LO, IM_HI]; combinational from F_PC.

Function
REQ-017 SHALL compute the branch target as D_PC + 4 + (sign_ext(D_imm16) << 2), modulo 2^32.
REQ-018 SHALL compute the j/jal target as {D_PC[31:28], D_imm26, 2'b00}.
REQ-019 SHALL use D_rs_val unmodified as the jr target; misalignment is reported only via F_adel.
REQ-020 SHALL assert redirect_now = !stall && (NPCOp==001 && b_result || NPCOp==010 || NPCOp==011).
REQ-021 SHALL define advance = !stall && imem_ready.
REQ-022 SHALL, on an advance cycle, load F_PC with the first applicable of: redirect_now target; held target if redirect_pending; F_PC + 4. It SHALL then clear redirect_pending.
REQ-023 SHALL, when redirect_now=1 and advance=0, capture the target into the held register, set redirect_pending=1, and hold F_PC.
REQ-024 SHALL, when redirect_now=1 and redirect_pending=1 in the same cycle, let the new target replace the held one (last resolved wins).
REQ-025 SHALL, when advance=0 and redirect_now=0, hold F_PC, the held register and redirect_pending unchanged.
REQ-026 SHALL ignore NPCOp and b_result whenever stall=1; the frozen D instruction re-resolves on the first unstalled cycle.
REQ-027 SHALL implement the delay slot implicitly: the instruction already in F when the redirect resolves is kept, and the target becomes the following F_PC.
REQ-028 SHALL wrap F_PC + 4 from 32'hFFFF_FFFC to 32'h0000_0000 without error.
REQ-029 SHALL drive F_adel = (F_PC[1:0] != 0) || F_PC < IM_LO || F_PC > IM_HI. F_adel SHALL NOT alter PC sequencing.
REQ-030 SHALL have a one-cycle latency from redirect_now to the new F_PC when imem_ready=1.

Reset
REQ-031 SHALL, on a clk edge with reset=1, set F_PC=PC_RESET, redirect_pending=0 and the held register=0, regardless of stall, imem_ready or redirect_now.
REQ-032 SHALL discard a pending redirect if reset is asserted mid-operation; the first post-reset fetch is PC_RESET.
REQ-033 SHALL have F_adel=0 after reset with default parameters.

Verification
REQ-034 SHALL cover: reset, then 3 cycles with imem_ready=1, NPCOp=000 -> F_PC = 3000, 3004, 3008, 300C.
REQ-035 SHALL cover: D_PC=3004, NPCOp=001, D_imm16=16'hFFFF, b_result=1, imem_ready=1 -> next F_PC=3004; with b_result=0 -> F_PC+4.
REQ-036 SHALL cover: NPCOp=011, D_rs_val=3402, stall=0, imem_ready=0 for 2 cycles then 1 -> redirect_pending=1 for 2 cycles; then F_PC=3402, F_adel=1, pending=0.
REQ-037 SHALL cover: stall=1 with NPCOp=010 for 3 cycles -> F_PC unchanged, redirect_pending=0; on stall release, F_PC={D_PC[31:28],imm26,00} the next cycle.
REQ-038 SHALL cover: pending target 3100 held while a new j target 3200 resolves, with imem_ready=0 -> the held target becomes 3200; the next advance gives F_PC=3200.
REQ-039 SHALL cover: reset asserted while redirect_pending=1 and stall=1 -> F_PC=3000, redirect_pending=0 the next cycle; and F_PC=FFFFFFFC advancing -> 00000000, F_adel=1.
